// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, sequential/branch target arithmetic, redirect
// arbitration against stalls with a one-deep pending buffer. Optional RAS under PC_RAS_EN.
module pc_sequencer #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      IMM_SHIFT = 2,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             stall_in,
  input  logic             br_take_in,
  input  logic [WIDTH-1:0] br_base_in,
  input  logic [WIDTH-1:0] br_imm_in,
  input  logic             jr_in,
  input  logic [WIDTH-1:0] jr_target_in,
  input  logic             jmp_in,
  input  logic [WIDTH-1:0] jmp_target_in,
  input  logic             ras_push_in,
  input  logic             ras_pop_in,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus_out,
  output logic [WIDTH-1:0] pc_minus_out,
  output logic             redirect_out,
  output logic             pend_out
);

  localparam logic [WIDTH-1:0] StepW = WIDTH'(STEP);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             pend_q, pend_d;
  logic             redirect_q, redirect_d;

  logic             redir_valid;
  logic [WIDTH-1:0] redir_tgt;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] jr_tgt;

  assign pc_out       = pc_q;
  assign pc_plus_out  = pc_q + StepW;
  assign pc_minus_out = pc_q - StepW;
  assign redirect_out = redirect_q;
  assign pend_out     = pend_q;

  assign br_tgt = br_base_in + (br_imm_in << IMM_SHIFT);

`ifdef PC_RAS_EN
  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PtrW:0] DepthW = (PtrW + 1)'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_mem_d [RAS_DEPTH];
  // ras_ptr_q names the next free slot; the top lives one below it.
  logic [PtrW-1:0]  ras_ptr_q, ras_ptr_d;
  logic [PtrW:0]    ras_cnt_q, ras_cnt_d;
  logic [PtrW-1:0]  ras_top_idx;
  logic             ras_pop;
  logic             ras_push;

  assign ras_top_idx = ras_ptr_q - PtrW'(1);
  // Pop only when jr actually wins arbitration and the stack holds something.
  assign ras_pop     = jr_in & ras_pop_in & ~br_take_in & (ras_cnt_q != '0);
  assign ras_push    = ras_push_in & ~stall_in;
  assign jr_tgt      = ras_pop ? ras_mem_q[ras_top_idx] : jr_target_in;

  always_comb begin
    ras_mem_d = ras_mem_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (ras_push && ras_pop) begin
      ras_mem_d[ras_top_idx] = pc_plus_out;
    end else if (ras_push) begin
      ras_mem_d[ras_ptr_q] = pc_plus_out;
      ras_ptr_d            = ras_ptr_q + PtrW'(1);
      if (ras_cnt_q != DepthW) begin
        ras_cnt_d = ras_cnt_q + (PtrW + 1)'(1);
      end
    end else if (ras_pop) begin
      ras_ptr_d = ras_top_idx;
      ras_cnt_d = ras_cnt_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  // Entries are qualified by the count, so the storage itself needs no reset.
  always_ff @(posedge Clk) begin
    ras_mem_q <= ras_mem_d;
  end
`else
  localparam int unsigned unused_ras_depth = RAS_DEPTH;
  logic unused_ras;
  assign unused_ras = ras_push_in ^ ras_pop_in;
  assign jr_tgt     = jr_target_in;
`endif

  always_comb begin
    redir_valid = br_take_in | jr_in | jmp_in;
    if (br_take_in) begin
      redir_tgt = br_tgt;
    end else if (jr_in) begin
      redir_tgt = jr_tgt;
    end else begin
      redir_tgt = jmp_target_in;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    redirect_d = 1'b0;
    if (redir_valid && !stall_in) begin
      pc_d       = redir_tgt;
      redirect_d = 1'b1;
      pend_d     = 1'b0;
    end else if (redir_valid) begin
      // Newest redirect during a stall replaces any older buffered one.
      pend_tgt_d = redir_tgt;
      pend_d     = 1'b1;
    end else if (!stall_in) begin
      if (pend_q) begin
        pc_d       = pend_tgt_q;
        pend_d     = 1'b0;
        redirect_d = 1'b1;
      end else begin
        pc_d = pc_plus_out;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      redirect_q <= redirect_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (RESET_PC 0x00400000 with RAS pins live, RESET_PC 0)
// checked every cycle against a behavioural model; RAS checks compile in with PC_RAS_EN.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        stall, br, jr, jmp, push, pop;
  logic [31:0] base, imm, jrt, jmpt;

  logic [31:0] pc0, plus0, minus0, pc1, plus1, minus1;
  logic        redir0, pend0, redir1, pend1;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  pc_sequencer #(
    .WIDTH(32), .STEP(4), .RESET_PC(32'h0040_0000), .IMM_SHIFT(2), .RAS_DEPTH(4)
  ) u_dut0 (
    .Clk(Clk), .Rst(Rst), .stall_in(stall),
    .br_take_in(br), .br_base_in(base), .br_imm_in(imm),
    .jr_in(jr), .jr_target_in(jrt), .jmp_in(jmp), .jmp_target_in(jmpt),
    .ras_push_in(push), .ras_pop_in(pop),
    .pc_out(pc0), .pc_plus_out(plus0), .pc_minus_out(minus0),
    .redirect_out(redir0), .pend_out(pend0)
  );

  pc_sequencer #(
    .WIDTH(32), .STEP(4), .RESET_PC(32'h0), .IMM_SHIFT(2), .RAS_DEPTH(4)
  ) u_dut1 (
    .Clk(Clk), .Rst(Rst), .stall_in(stall),
    .br_take_in(br), .br_base_in(base), .br_imm_in(imm),
    .jr_in(jr), .jr_target_in(jrt), .jmp_in(jmp), .jmp_target_in(jmpt),
    .ras_push_in(1'b0), .ras_pop_in(1'b0),
    .pc_out(pc1), .pc_plus_out(plus1), .pc_minus_out(minus1),
    .redirect_out(redir1), .pend_out(pend1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: PC, pending buffer, redirect pulse per instance; RAS as a plain queue.
  logic [31:0] m_pc [2];
  logic [31:0] m_ptgt [2];
  bit          m_pend [2];
  bit          m_redir [2];
  logic [31:0] ras_q [$];
  bit          mvalid = 1'b0;

  always @(posedge Clk) begin
    logic [31:0] tgt;
    bit          red;
    bit          use_pop;
    for (int i = 0; i < 2; i++) begin
      if (Rst) begin
        m_pc[i]    = (i == 0) ? 32'h0040_0000 : 32'h0;
        m_pend[i]  = 1'b0;
        m_redir[i] = 1'b0;
        if (i == 0) ras_q.delete();
      end else begin
        red     = br || jr || jmp;
        use_pop = 1'b0;
`ifdef PC_RAS_EN
        use_pop = (i == 0) && jr && pop && !br && (ras_q.size() != 0);
`endif
        if (br)      tgt = base + (imm * 4);
        else if (jr) tgt = use_pop ? ras_q[ras_q.size() - 1] : jrt;
        else         tgt = jmpt;
`ifdef PC_RAS_EN
        if (i == 0) begin
          if (use_pop) void'(ras_q.pop_back());
          if (push && !stall) begin
            ras_q.push_back(m_pc[i] + 32'd4);
            if (ras_q.size() > 4) void'(ras_q.pop_front());
          end
        end
`endif
        if (red && !stall) begin
          m_pc[i] = tgt; m_redir[i] = 1'b1; m_pend[i] = 1'b0;
        end else if (red) begin
          m_ptgt[i] = tgt; m_pend[i] = 1'b1; m_redir[i] = 1'b0;
        end else if (stall) begin
          m_redir[i] = 1'b0;
        end else if (m_pend[i]) begin
          m_pc[i] = m_ptgt[i]; m_pend[i] = 1'b0; m_redir[i] = 1'b1;
        end else begin
          m_pc[i] = m_pc[i] + 32'd4; m_redir[i] = 1'b0;
        end
      end
    end
    if (Rst) mvalid = 1'b1;
  end

  always @(negedge Clk) begin
    if (mvalid) begin
      check("pc0", pc0, m_pc[0]);
      check("plus0", plus0, m_pc[0] + 32'd4);
      check("minus0", minus0, m_pc[0] - 32'd4);
      check("redir0", {31'b0, redir0}, {31'b0, m_redir[0]});
      check("pend0", {31'b0, pend0}, {31'b0, m_pend[0]});
      check("pc1", pc1, m_pc[1]);
      check("plus1", plus1, m_pc[1] + 32'd4);
      check("minus1", minus1, m_pc[1] - 32'd4);
      check("redir1", {31'b0, redir1}, {31'b0, m_redir[1]});
      check("pend1", {31'b0, pend1}, {31'b0, m_pend[1]});
    end
  end

  task automatic clr();
    stall = 0; br = 0; jr = 0; jmp = 0; push = 0; pop = 0;
    base = 0; imm = 0; jrt = 0; jmpt = 0;
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  logic [31:0] ras_exp [5];

  initial begin
    Rst = 1'b1;
    clr();
    tick(); tick();
    check("rst_pc", pc0, 32'h0040_0000);
    check("rst_plus", plus0, 32'h0040_0004);
    check("rst_minus", minus0, 32'h003F_FFFC);
    check("rst_minus_zero", minus1, 32'hFFFF_FFFC);
    check("rst_redir", {31'b0, redir0}, 32'h0);
    check("rst_pend", {31'b0, pend0}, 32'h0);

    Rst = 1'b0;
    tick(); tick(); tick();
    check("seq3_pc", pc0, 32'h0040_000C);
    check("seq3_redir", {31'b0, redir0}, 32'h0);

    br = 1; base = 32'h100; imm = 32'hFFFF_FFFE;
    tick();
    check("br_pc", pc0, 32'h0000_00F8);
    check("br_redir", {31'b0, redir0}, 32'h1);
    clr();
    tick();
    check("br_redir_drop", {31'b0, redir0}, 32'h0);
    check("br_seq_pc", pc0, 32'h0000_00FC);

    br = 1; base = 32'h200; imm = 0; jr = 1; jrt = 32'h300; jmp = 1; jmpt = 32'h400;
    tick();
    check("prio_pc", pc0, 32'h200);
    clr();

    stall = 1; jmp = 1; jmpt = 32'h500;
    tick();
    check("stall1_pc", pc0, 32'h200);
    check("stall1_pend", {31'b0, pend0}, 32'h1);
    jmpt = 32'h600;
    tick();
    jmp = 0;
    tick();
    check("stall3_pc", pc0, 32'h200);
    check("stall3_redir", {31'b0, redir0}, 32'h0);
    stall = 0;
    tick();
    check("release_pc", pc0, 32'h600);
    check("release_redir", {31'b0, redir0}, 32'h1);
    check("release_pend", {31'b0, pend0}, 32'h0);

    stall = 1; jmp = 1; jmpt = 32'h500;
    tick();
    jmpt = 32'h600;
    tick();
    jmp = 0;
    tick();
    stall = 0; br = 1; base = 32'h700; imm = 0;
    tick();
    check("live_wins_pc", pc0, 32'h700);
    check("live_wins_pend", {31'b0, pend0}, 32'h0);
    clr();
    tick();
    check("discard_pc", pc0, 32'h704);

    jmp = 1; jmpt = 32'hFFFF_FFFC;
    tick();
    check("top_pc", pc0, 32'hFFFF_FFFC);
    check("top_plus", plus0, 32'h0);
    clr();
    tick();
    check("wrap_pc", pc0, 32'h0);
    check("wrap_minus", minus0, 32'hFFFF_FFFC);

`ifdef PC_RAS_EN
    jmp = 1; jmpt = 32'h10;
    tick();
    for (int k = 1; k <= 5; k++) begin
      push = 1; jmp = 1; jmpt = 32'(k + 1) * 32'h10;
      tick();
    end
    clr();
    ras_exp[0] = 32'h54; ras_exp[1] = 32'h44; ras_exp[2] = 32'h34;
    ras_exp[3] = 32'h24; ras_exp[4] = 32'hABC0;
    for (int k = 0; k < 5; k++) begin
      jr = 1; pop = 1; jrt = 32'hABC0;
      tick();
      check($sformatf("ras_pop%0d", k), pc0, ras_exp[k]);
    end
    clr();
    push = 1;
    tick(); tick();
    push = 0; Rst = 1;
    tick();
    Rst = 0; jr = 1; pop = 1; jrt = 32'h1230;
    tick();
    check("ras_rst_empty", pc0, 32'h1230);
    clr();
`endif

    for (int n = 0; n < 3000; n++) begin
      Rst   = ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 2) == 0);
      br    = ($urandom_range(0, 5) == 0);
      jr    = ($urandom_range(0, 5) == 0);
      jmp   = ($urandom_range(0, 5) == 0);
      push  = ($urandom_range(0, 2) == 0);
      pop   = ($urandom_range(0, 1) == 0);
      base  = $urandom & 32'hFFFF_FFFC;
      imm   = 32'($urandom_range(0, 63)) - 32'd32;
      jrt   = $urandom & 32'hFFFF_FFFC;
      jmpt  = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    clr();
    Rst = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
